// File: rtl/afu_frm_fetch.sv
// Host-memory line fetcher feeding the turbo-decoder input converter.
// Reads a job of consecutive lines into a small FIFO and forwards them frame by frame.
module afu_frm_fetch #(
    parameter int BUS        = 512,
    parameter int BUS_HEAD   = 16,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int w_NumLines = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [w_NumLines-1:0] num_lines,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frm_cnt,
    output logic                  rd_req_valid,
    output logic [ADDR_W-1:0]     rd_req_addr,
    input  logic                  rd_req_ready,
    input  logic                  rd_rsp_valid,
    input  logic [BUS-1:0]        rd_rsp_data,
    output logic [BUS-1:0]        bus_data,
    output logic                  bus_en,
    input  logic                  bus_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {J_IDLE, J_RUN, J_DONE} job_state_t;
    typedef enum logic [1:0] {F_SEND, F_HOLD_LO, F_HOLD_HI} fwd_state_t;

    job_state_t job_state, job_next;
    fwd_state_t fwd_state, fwd_next;

    logic [ADDR_W-1:0]     base_r;
    logic [w_NumLines-1:0] num_r;
    logic [w_NumLines-1:0] req_cnt;
    logic [w_NumLines-1:0] fwd_cnt;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit_used;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [BUS-1:0]        fifo_mem [FIFO_DEPTH];

    logic job_start;
    logic req_hs;
    logic pop;
    logic pop_eof;

    // Outstanding reads plus buffered lines never exceed the FIFO, so responses always fit.
    assign credit_used  = {1'b0, inflight} + {1'b0, fifo_count};
    assign job_start    = (job_state == J_IDLE) && start;
    assign rd_req_valid = (job_state == J_RUN) && (req_cnt < num_r)
                          && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign rd_req_addr  = base_r + ADDR_W'(req_cnt);
    assign req_hs       = rd_req_valid && rd_req_ready;
    assign pop          = (fwd_state == F_SEND) && (fifo_count != '0) && bus_ready;
    assign pop_eof      = pop && fifo_mem[rd_ptr][BUS_HEAD-2];

    always_comb begin
        job_next = job_state;
        done     = 1'b0;
        case (job_state)
            J_IDLE: if (start) job_next = J_RUN;
            J_RUN:  if (fwd_cnt == num_r) job_next = J_DONE;
            J_DONE: begin
                done     = 1'b1;
                job_next = J_IDLE;
            end
            default: job_next = J_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_state <= J_IDLE;
            busy      <= 1'b0;
            base_r    <= '0;
            num_r     <= '0;
            req_cnt   <= '0;
        end else begin
            job_state <= job_next;
            if (job_start) begin
                busy    <= 1'b1;
                base_r  <= base_addr;
                num_r   <= num_lines;
                req_cnt <= '0;
            end else begin
                if (job_state == J_DONE) busy <= 1'b0;
                if (req_hs) req_cnt <= req_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            inflight   <= inflight + CNT_W'(req_hs) - CNT_W'(rd_rsp_valid);
            fifo_count <= fifo_count + CNT_W'(rd_rsp_valid) - CNT_W'(pop);
            if (rd_rsp_valid) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_rsp_valid) fifo_mem[wr_ptr] <= rd_rsp_data;
    end

    // After an end-of-frame word, wait for the converter to close and re-open its window.
    always_comb begin
        fwd_next = fwd_state;
        case (fwd_state)
            F_SEND:    if (pop_eof) fwd_next = F_HOLD_LO;
            F_HOLD_LO: if (!bus_ready) fwd_next = F_HOLD_HI;
            F_HOLD_HI: if (bus_ready) fwd_next = F_SEND;
            default:   fwd_next = F_SEND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_state <= F_SEND;
            bus_en    <= 1'b0;
            bus_data  <= '0;
            fwd_cnt   <= '0;
            frm_cnt   <= '0;
        end else begin
            fwd_state <= fwd_next;
            bus_en    <= pop;
            if (pop) bus_data <= fifo_mem[rd_ptr];
            if (job_start) begin
                fwd_cnt <= '0;
                frm_cnt <= '0;
            end else if (pop) begin
                fwd_cnt <= fwd_cnt + 1'b1;
                if (pop_eof && (frm_cnt != 16'hFFFF)) frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_afu_frm_fetch.sv
// Directed bench for afu_frm_fetch: in-order memory model with 2-cycle read latency,
// bus monitor, and immediate-assertion checks against hand-computed expectations.
module tb_afu_frm_fetch;
    localparam int BUS      = 512;
    localparam int BUS_HEAD = 16;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [31:0]     base_addr;
    logic [15:0]     num_lines;
    logic            busy;
    logic            done;
    logic [15:0]     frm_cnt;
    logic            rd_req_valid;
    logic [31:0]     rd_req_addr;
    logic            rd_req_ready;
    logic            rd_rsp_valid;
    logic [BUS-1:0]  rd_rsp_data;
    logic [BUS-1:0]  bus_data;
    logic            bus_en;
    logic            bus_ready;

    afu_frm_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .busy         (busy),
        .done         (done),
        .frm_cnt      (frm_cnt),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_ready (rd_req_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .bus_data     (bus_data),
        .bus_en       (bus_en),
        .bus_ready    (bus_ready)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Stimulus-owned controls for the memory model
    logic        rand_ready = 1'b0;
    logic [31:0] job_base   = '0;
    logic [31:0] eof_mask   = '0;
    int          start_cyc  = 0;

    // Memory-model-owned records
    logic [31:0] req_log[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          rsp_cnt          = 0;
    int          req_valid_cycles = 0;
    int          unstable_cnt     = 0;
    logic        wait_pending     = 1'b0;
    logic [31:0] wait_addr        = '0;

    // Monitor-owned records
    logic [BUS-1:0] got_data[$];
    int             en_cyc[$];
    int             done_cnt     = 0;
    int             done_cyc     = 0;
    int             en_while_low = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BUS-1:0] make_line(input logic [31:0] addr, input logic eof);
        logic [BUS-1:0] w;
        w = '0;
        w[BUS-1 -: 32]     = addr;
        w[BUS_HEAD +: 32]  = ~addr;
        w[BUS_HEAD-2]      = eof;
        return w;
    endfunction

    function automatic logic eof_of(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr - job_base;
        return (idx < 32) ? eof_mask[idx[4:0]] : 1'b0;
    endfunction

    // In-order memory: a request accepted at edge k returns data sampled at edge k+2
    initial begin
        rd_req_ready = 1'b1;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && rd_req_valid) begin
                req_valid_cycles++;
                if (wait_pending && (rd_req_addr != wait_addr)) unstable_cnt++;
                if (rd_req_ready) begin
                    req_log.push_back(rd_req_addr);
                    pend_addr.push_back(rd_req_addr);
                    pend_due.push_back(cyc + 2);
                    wait_pending = 1'b0;
                end else begin
                    wait_pending = 1'b1;
                    wait_addr    = rd_req_addr;
                end
            end else if (rst_n && wait_pending) begin
                unstable_cnt++;
                wait_pending = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                wait_pending = 1'b0;
            end
            rd_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = make_line(pend_addr[0], eof_of(pend_addr[0]));
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                rsp_cnt++;
            end else begin
                rd_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_en) begin
                got_data.push_back(bus_data);
                en_cyc.push_back(cyc);
                if (!bus_ready) en_while_low++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [BUS-1:0] observed,
                                input logic [BUS-1:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] base, input logic [15:0] num,
                                  input logic [31:0] mask);
        job_base  = base;
        eof_mask  = mask;
        base_addr = base;
        num_lines = num;
        start     = 1'b1;
        start_cyc = cyc;
        step(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int max_cycles);
        int n;
        n = 0;
        while ((done_cnt == d0) && (n < max_cycles)) begin
            step(1);
            n++;
        end
        check_output({tag, "_done"}, BUS'(done_cnt - d0), BUS'(1));
    endtask

    task automatic check_words(input string tag, input int w0, input logic [31:0] base,
                               input int n, input logic [31:0] mask);
        logic [31:0]    a;
        logic [BUS-1:0] obs;
        check_output({tag, "_count"}, BUS'(got_data.size() - w0), BUS'(n));
        for (int i = 0; i < n; i++) begin
            a   = base + 32'(i);
            obs = (w0 + i < got_data.size()) ? got_data[w0 + i] : '0;
            check_output($sformatf("%s_word%0d", tag, i), obs, make_line(a, mask[i]));
        end
    endtask

    task automatic clear_hold();
        bus_ready = 1'b0;
        step(2);
        bus_ready = 1'b1;
        step(2);
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        int rs0;
        int rv0;
        int u0;
        int n;
        int rise_cyc;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_lines = '0;
        bus_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2);
        $display("[TB] reset state");
        check_output("rst_busy", BUS'(busy), BUS'(0));
        check_output("rst_done", BUS'(done), BUS'(0));
        check_output("rst_frm_cnt", BUS'(frm_cnt), BUS'(0));
        check_output("rst_req_valid", BUS'(rd_req_valid), BUS'(0));
        check_output("rst_bus_en", BUS'(bus_en), BUS'(0));
        check_output("rst_bus_data", bus_data, '0);

        $display("[TB] single frame");
        d0 = done_cnt; w0 = got_data.size(); r0 = req_log.size();
        apply_stimulus(32'h0000_1000, 16'd4, 32'h8);
        check_output("t2_busy", BUS'(busy), BUS'(1));
        wait_done("t2", d0, 60);
        check_output("t2_busy_after", BUS'(busy), BUS'(0));
        check_words("t2", w0, 32'h0000_1000, 4, 32'h8);
        check_output("t2_consecutive", BUS'(en_cyc[w0 + 3] - en_cyc[w0]), BUS'(3));
        check_output("t2_done_timing", BUS'(done_cyc - en_cyc[w0 + 3]), BUS'(1));
        check_output("t2_frm_cnt", BUS'(frm_cnt), BUS'(1));
        check_output("t2_requests", BUS'(req_log.size() - r0), BUS'(4));

        $display("[TB] two frames");
        clear_hold();
        d0 = done_cnt; w0 = got_data.size();
        apply_stimulus(32'h0000_2000, 16'd6, 32'h24);
        n = 0;
        while ((got_data.size() < w0 + 3) && (n < 60)) begin
            step(1);
            n++;
        end
        check_output("t3_first_frame", BUS'(got_data.size() - w0), BUS'(3));
        bus_ready = 1'b0;
        step(20);
        check_output("t3_hold_quiet", BUS'(got_data.size() - w0), BUS'(3));
        bus_ready = 1'b1;
        rise_cyc  = cyc;
        wait_done("t3", d0, 60);
        check_output("t3_line3_latency", BUS'(en_cyc[w0 + 3] - rise_cyc), BUS'(2));
        check_words("t3", w0, 32'h0000_2000, 6, 32'h24);
        check_output("t3_frm_cnt", BUS'(frm_cnt), BUS'(2));
        check_output("t3_en_while_low", BUS'(en_while_low), BUS'(0));

        $display("[TB] credit limit");
        bus_ready = 1'b0;
        d0 = done_cnt; w0 = got_data.size(); r0 = req_log.size();
        apply_stimulus(32'h0000_3000, 16'd20, 32'h0);
        step(40);
        check_output("t4_reqs_capped", BUS'(req_log.size() - r0), BUS'(8));
        check_output("t4_no_fwd", BUS'(got_data.size() - w0), BUS'(0));
        check_output("t4_busy", BUS'(busy), BUS'(1));
        bus_ready = 1'b1;
        wait_done("t4", d0, 300);
        check_words("t4", w0, 32'h0000_3000, 20, 32'h0);
        check_output("t4_reqs_total", BUS'(req_log.size() - r0), BUS'(20));
        check_output("t4_frm_cnt", BUS'(frm_cnt), BUS'(0));

        $display("[TB] reset mid job");
        bus_ready = 1'b0;
        d0 = done_cnt; rs0 = rsp_cnt;
        apply_stimulus(32'h0000_4000, 16'd8, 32'h0);
        n = 0;
        while ((rsp_cnt - rs0 < 3) && (n < 40)) begin
            step(1);
            n++;
        end
        step(1);
        check_output("t1_busy_before", BUS'(busy), BUS'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t1_busy", BUS'(busy), BUS'(0));
        check_output("t1_done", BUS'(done), BUS'(0));
        check_output("t1_frm_cnt", BUS'(frm_cnt), BUS'(0));
        check_output("t1_req_valid", BUS'(rd_req_valid), BUS'(0));
        check_output("t1_bus_en", BUS'(bus_en), BUS'(0));
        check_output("t1_bus_data", bus_data, '0);
        step(3);
        rst_n = 1'b1;
        step(2);
        check_output("t1_no_done", BUS'(done_cnt - d0), BUS'(0));
        bus_ready = 1'b1;
        d0 = done_cnt; w0 = got_data.size(); r0 = req_log.size();
        apply_stimulus(32'h0000_5000, 16'd2, 32'h2);
        wait_done("t1_restart", d0, 60);
        check_words("t1_restart", w0, 32'h0000_5000, 2, 32'h2);
        check_output("t1_restart_reqs", BUS'(req_log.size() - r0), BUS'(2));
        check_output("t1_restart_frm_cnt", BUS'(frm_cnt), BUS'(1));

        $display("[TB] request backpressure and address wrap");
        clear_hold();
        rand_ready = 1'b1;
        d0 = done_cnt; w0 = got_data.size(); r0 = req_log.size(); u0 = unstable_cnt;
        apply_stimulus(32'hFFFF_FFFE, 16'd5, 32'h10);
        wait_done("t5", d0, 400);
        rand_ready = 1'b0;
        check_output("t5_reqs", BUS'(req_log.size() - r0), BUS'(5));
        check_output("t5_addr0", BUS'(req_log[r0 + 0]), BUS'(32'hFFFF_FFFE));
        check_output("t5_addr1", BUS'(req_log[r0 + 1]), BUS'(32'hFFFF_FFFF));
        check_output("t5_addr2", BUS'(req_log[r0 + 2]), BUS'(32'h0000_0000));
        check_output("t5_addr3", BUS'(req_log[r0 + 3]), BUS'(32'h0000_0001));
        check_output("t5_addr4", BUS'(req_log[r0 + 4]), BUS'(32'h0000_0002));
        check_output("t5_stable", BUS'(unstable_cnt - u0), BUS'(0));
        check_words("t5", w0, 32'hFFFF_FFFE, 5, 32'h10);
        check_output("t5_frm_cnt", BUS'(frm_cnt), BUS'(1));

        $display("[TB] zero-length job");
        clear_hold();
        d0 = done_cnt; w0 = got_data.size(); rv0 = req_valid_cycles;
        apply_stimulus(32'h0000_6000, 16'd0, 32'h0);
        wait_done("t6_zero", d0, 10);
        check_output("t6_zero_done_timing", BUS'(done_cyc - start_cyc), BUS'(2));
        check_output("t6_zero_no_req", BUS'(req_valid_cycles - rv0), BUS'(0));
        check_output("t6_zero_no_fwd", BUS'(got_data.size() - w0), BUS'(0));

        $display("[TB] start while busy");
        d0 = done_cnt; w0 = got_data.size(); r0 = req_log.size();
        apply_stimulus(32'h0000_7000, 16'd3, 32'h4);
        base_addr = 32'h0000_9000;
        num_lines = 16'd10;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
        wait_done("t6_busy", d0, 100);
        step(3);
        check_output("t6_busy_single_done", BUS'(done_cnt - d0), BUS'(1));
        check_output("t6_busy_reqs", BUS'(req_log.size() - r0), BUS'(3));
        check_output("t6_busy_last_addr", BUS'(req_log[r0 + 2]), BUS'(32'h0000_7002));
        check_words("t6_busy", w0, 32'h0000_7000, 3, 32'h4);
        check_output("t6_busy_frm_cnt", BUS'(frm_cnt), BUS'(1));
        check_output("t6_idle", BUS'(busy), BUS'(0));
        check_output("all_en_while_low", BUS'(en_while_low), BUS'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
